rgb_frame_ctrl: RTL

//  Frame controller behind the RGB serial receiver (cmd/len/R/G/B/checksum frame).
//  - Accepts decoded frames, validates checksum and length, decodes the command.
//  - Sequences the colour registers: immediate SET, timed FADE, or OFF.
//  - Reports status/errors and optionally drives 3-channel PWM.

---
 rtl/rgb_pkg.sv | 53 +++++
 rtl/rgb_pwm_ch.sv | 10 +
 rtl/rgb_frame_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/rgb_pkg.sv
// Shared types and constants for the RGB frame controller: commands, FSM states,
// reject codes, the captured frame record and the checksum/step helpers.
package rgb_pkg;

   localparam logic [7:0] CMD_SET  = 8'h01;
   localparam logic [7:0] CMD_FADE = 8'h02;
   localparam logic [7:0] CMD_OFF  = 8'h03;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CHECK = 2'd1,
      ST_APPLY = 2'd2,
      ST_FADE  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_CHK  = 2'd1,
      ERR_LEN  = 2'd2,
      ERR_CMD  = 2'd3
   } err_e;

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] len;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic [7:0] chk;
   } frame_t;

   // Packed colour triple, element 0 = red, 1 = green, 2 = blue.
   typedef logic [2:0][7:0] rgb_t;

   function automatic logic [7:0] frame_xor(input frame_t f);
      return f.cmd ^ f.len ^ f.r ^ f.g ^ f.b;
   endfunction

   // Rejection reasons are tested in priority order: checksum, length, command.
   function automatic err_e frame_check(input frame_t f, input logic [7:0] exp_len);
      if (f.chk != frame_xor(f)) return ERR_CHK;
      if (f.len != exp_len) return ERR_LEN;
      if (!(f.cmd inside {CMD_SET, CMD_FADE, CMD_OFF})) return ERR_CMD;
      return ERR_NONE;
   endfunction

   function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
      if (cur < tgt) return cur + 8'd1;
      if (cur > tgt) return cur - 8'd1;
      return cur;
   endfunction

endpackage

// File: rtl/rgb_pwm_ch.sv
// Single PWM channel: output is high while the shared counter is below the level.
module rgb_pwm_ch (
   input  logic [7:0] level_i,
   input  logic [7:0] cnt_i,
   output logic       pwm_o
);

   assign pwm_o = (cnt_i < level_i);

endmodule

// File: rtl/rgb_frame_ctrl.sv
// Frame controller behind the RGB serial receiver: checks frames, runs SET/FADE/OFF.
// Optional 3-channel PWM output is built when RGB_PWM_EN is defined.
module rgb_frame_ctrl
   import rgb_pkg::*;
#(
   parameter int unsigned STEP_DIV = 1000,
   parameter logic [7:0]  EXP_LEN  = 8'd3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frm_valid,
   input  logic [7:0] frm_cmd,
   input  logic [7:0] frm_len,
   input  logic [7:0] frm_r,
   input  logic [7:0] frm_g,
   input  logic [7:0] frm_b,
   input  logic [7:0] frm_chk,
   output logic [7:0] led_r,
   output logic [7:0] led_g,
   output logic [7:0] led_b,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       fade_done,
   output logic       busy,
   output logic       rx_ovf,
   output logic [1:0] state,
   output logic       pwm_r,
   output logic       pwm_g,
   output logic       pwm_b
);

   localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DIV - 1);

   state_e           state_q, state_d;
   frame_t           slot_q, slot_d;
   logic             slot_full_q, slot_full_d;
   frame_t           work_q, work_d;
   rgb_t             led_q, led_d;
   rgb_t             tgt_q, tgt_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic             frame_ok_q, frame_ok_d;
   logic             frame_err_q, frame_err_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             fade_done_q, fade_done_d;
   logic             rx_ovf_q, rx_ovf_d;

   frame_t frm_in;
   err_e   chk_res;
   rgb_t   led_step;
   logic   slot_pop;

   assign frm_in = '{cmd: frm_cmd, len: frm_len, r: frm_r, g: frm_g, b: frm_b, chk: frm_chk};

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      slot_full_d = slot_full_q;
      work_d      = work_q;
      led_d       = led_q;
      tgt_d       = tgt_q;
      step_cnt_d  = step_cnt_q;
      frame_ok_d  = 1'b0;
      frame_err_d = 1'b0;
      err_code_d  = err_code_q;
      fade_done_d = 1'b0;
      rx_ovf_d    = rx_ovf_q;
      slot_pop    = 1'b0;
      chk_res     = frame_check(work_q, EXP_LEN);
      for (int i = 0; i < 3; i++) begin
         led_step[i] = step_toward(led_q[i], tgt_q[i]);
      end

      case (state_q)
         ST_IDLE: begin
            if (slot_full_q) begin
               state_d  = ST_CHECK;
               work_d   = slot_q;
               slot_pop = 1'b1;
            end
         end
         ST_CHECK: begin
            if (chk_res != ERR_NONE) begin
               state_d     = ST_IDLE;
               frame_err_d = 1'b1;
               err_code_d  = chk_res;
            end else begin
               state_d = ST_APPLY;
            end
         end
         ST_APPLY: begin
            frame_ok_d = 1'b1;
            state_d    = ST_IDLE;
            case (work_q.cmd)
               CMD_SET: led_d = {work_q.b, work_q.g, work_q.r};
               CMD_OFF: led_d = '0;
               CMD_FADE: begin
                  tgt_d      = {work_q.b, work_q.g, work_q.r};
                  step_cnt_d = '0;
                  state_d    = ST_FADE;
               end
               default: ;
            endcase
         end
         ST_FADE: begin
            // A waiting frame pre-empts the fade; the LEDs freeze where they are.
            if (slot_full_q) begin
               state_d  = ST_CHECK;
               work_d   = slot_q;
               slot_pop = 1'b1;
            end else if (step_cnt_q == STEP_LAST) begin
               step_cnt_d = '0;
               led_d      = led_step;
               if (led_step == tgt_q) begin
                  state_d     = ST_IDLE;
                  fade_done_d = 1'b1;
               end
            end else begin
               step_cnt_d = step_cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The slot can be drained and refilled on the same edge.
      if (slot_pop) slot_full_d = 1'b0;
      if (frm_valid) begin
         if (!slot_full_q || slot_pop) begin
            slot_d      = frm_in;
            slot_full_d = 1'b1;
         end else begin
            rx_ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         slot_q      <= '0;
         slot_full_q <= 1'b0;
         work_q      <= '0;
         led_q       <= '0;
         tgt_q       <= '0;
         step_cnt_q  <= '0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= 2'd0;
         fade_done_q <= 1'b0;
         rx_ovf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         slot_full_q <= slot_full_d;
         work_q      <= work_d;
         led_q       <= led_d;
         tgt_q       <= tgt_d;
         step_cnt_q  <= step_cnt_d;
         frame_ok_q  <= frame_ok_d;
         frame_err_q <= frame_err_d;
         err_code_q  <= err_code_d;
         fade_done_q <= fade_done_d;
         rx_ovf_q    <= rx_ovf_d;
      end
   end

   assign led_r     = led_q[0];
   assign led_g     = led_q[1];
   assign led_b     = led_q[2];
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;
   assign fade_done = fade_done_q;
   assign rx_ovf    = rx_ovf_q;
   assign state     = state_q;
   assign busy      = (state_q != ST_IDLE);

`ifdef RGB_PWM_EN
   // Period of 255 lets level 0 mean always off and level 255 always on.
   logic [7:0] pwm_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt_q <= 8'd0;
      end else begin
         pwm_cnt_q <= (pwm_cnt_q == 8'd254) ? 8'd0 : pwm_cnt_q + 8'd1;
      end
   end

   rgb_pwm_ch u_pwm_r (.level_i(led_q[0]), .cnt_i(pwm_cnt_q), .pwm_o(pwm_r));
   rgb_pwm_ch u_pwm_g (.level_i(led_q[1]), .cnt_i(pwm_cnt_q), .pwm_o(pwm_g));
   rgb_pwm_ch u_pwm_b (.level_i(led_q[2]), .cnt_i(pwm_cnt_q), .pwm_o(pwm_b));
`else
   assign pwm_r = 1'b0;
   assign pwm_g = 1'b0;
   assign pwm_b = 1'b0;
`endif

endmodule
